uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter: the upstream partner of the UART receiver. It serialises bytes onto the `tx` line in 8N1 format (1 start, 8 data LSB-first, STOP_BITS stop).
- Contains a small byte FIFO so a producer can write bursts through a valid/ready handshake.
- Its `tx` output drives the receiver's `rx` input in loopback and board-level tests.

Parameters:
- CLK_HZ, 66_000_000, system clock frequency in Hz.
- BITRATE_BPS, 9_600, serial bit rate.
- BIT_CLK, round(CLK_HZ/BITRATE_BPS) = 6875, clocks per bit (derived; not overridden directly).
- FIFO_DEPTH, 8, byte FIFO depth (power of 2, >=2).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_in_valid  in  1  producer has a byte on data_in.
- data_in_ready  out  1  FIFO can accept a byte this cycle.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  a frame is in progress (START/DATA/STOP).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Behaviour:
- Interface: one clock (`clk`). Reset `rst` is synchronous and active-high.
- Reset values: tx=1, busy=0, data_in_ready=1, fifo_count=0. FIFO pointers cleared, state=IDLE, bit counter=0, tick counter=0.
- Reset mid-frame: frame is abandoned and FIFO flushed. tx is 1 from the first edge with rst high.
- Handshake and FIFO:
  - A write occurs on any edge where data_in_valid && data_in_ready.
  - data_in_ready = (fifo_count < FIFO_DEPTH), computed from the registered count. When full it stays 0 even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Writes while full are ignored (ready=0), and data is never overwritten.
- State machine:
  - IDLE: tx=1, busy=0. If FIFO non-empty: pop head into shift register, tick=0, go START.
  - START: tx=0 for exactly BIT_CLK cycles, then go DATA with bit index 0.
  - DATA:
    - tx = shift[0] for BIT_CLK cycles, then shift right and increment the index.
    - After index 7 completes, go STOP.
  - STOP: tx=1 for STOP_BITS*BIT_CLK cycles. Then:
    - if FIFO non-empty, pop and go directly to START (back-to-back, no idle gap);
    - else go to IDLE.
- busy=1 exactly while state is START, DATA or STOP.
- Latency: a byte written at edge N into an empty FIFO with state IDLE is popped at edge N+1. tx falls on edge N+2.
- Frame length is (1+8+STOP_BITS)*BIT_CLK cycles exactly, with no jitter and no cumulative drift.
- The tick counter is wide enough for STOP_BITS*BIT_CLK. It compares against BIT_CLK-1 and resets to 0.
- tx is driven from a flop only, so it is glitch-free.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - function calc_bit_clk(clk_hz, bitrate) returning a rounded int;
  - localparam DATA_BITS=8.
- Sub-module uart_byte_fifo (parameter DEPTH, width 8, synchronous, count output). uart_tx instantiates it plus the serialiser FSM.

Test Plan (CLK_HZ=1_000_000, BITRATE_BPS=100_000, so BIT_CLK=10, unless stated):
- Single byte 0x55 written in idle -> tx low from 2 clocks after write:
  - then 1,0,1,0,1,0,1,0 (LSB first), each 10 cycles;
  - stop high 10 cycles;
  - busy high 100 cycles; tx high afterwards.
- Burst of 3 bytes 0xA5,0x00,0xFF on consecutive cycles -> three 100-cycle frames back-to-back with no idle gap. fifo_count peaks at 2, returns to 0.
- Hold valid for 12 writes while the first frame sends:
  - ready drops after the FIFO holds 8;
  - exactly 9 bytes are accepted (1 popped, 8 queued);
  - all transmit in order, none duplicated.
- STOP_BITS=2, byte 0x80 -> stop phase lasts 20 cycles; total frame 110 cycles.
- rst asserted for 1 cycle mid-DATA of 0x3C with 2 bytes queued:
  - tx=1 and busy=0 from that edge;
  - fifo_count=0;
  - no further frames until new writes.
- Loopback tx -> UART receiver at the default 66 MHz / 9600 bps, bytes 0x00, 0x5A, 0xFF -> receiver data matches on each data_valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and bit-period helper for the UART transmitter
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic int calc_bit_clk(input int clk_hz, input int bitrate);
    return (clk_hz + bitrate / 2) / bitrate;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with occupancy count and full/empty flags
module uart_byte_fifo import uart_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [DATA_BITS-1:0]   i_wr_data,
  input  logic                   i_rd_en,
  output logic [DATA_BITS-1:0]   o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_push, w_pop;
  assign o_full    = r_count == CW'(DEPTH);
  assign o_empty   = r_count == '0;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serialiser with registered, glitch-free tx line
module uart_tx import uart_pkg::*; #(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600,
  parameter int FIFO_DEPTH  = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int BIT_CLK  = calc_bit_clk(CLK_HZ, BITRATE_BPS);
  localparam int STOP_CLK = STOP_BITS * BIT_CLK;
  localparam int TW       = $clog2(STOP_CLK + 1);
  localparam int IW       = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_END  = TW'(BIT_CLK - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STOP_CLK - 1);
  tx_state_t            r_state, w_state;
  logic [TW-1:0]        r_tick, w_tick;
  logic [IW-1:0]        r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift, w_head;
  logic                 r_tx, w_pop, w_full, w_empty, w_done;
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (data_in_valid),
    .i_wr_data (data_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );
  assign data_in_ready = !w_full;
  assign busy          = r_state != IDLE;
  assign tx            = r_tx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
    end
  end
  // STOP may span several bit periods, so its end-of-phase limit differs
  always_comb begin
    w_done  = r_tick == (r_state == STOP ? STOP_END : BIT_END);
    w_state = r_state;
    w_tick  = w_done ? '0 : r_tick + TW'(1);
    w_idx   = r_idx;
    w_shift = r_shift;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_shift = w_head;
          w_state = START;
        end
      end
      START: if (w_done) begin
        w_idx   = '0;
        w_state = DATA;
      end
      DATA: if (w_done) begin
        w_shift = r_shift >> 1;
        w_idx   = r_idx + IW'(1);
        if (r_idx == IW'(DATA_BITS - 1)) w_state = STOP;
      end
      STOP: if (w_done) begin
        w_pop   = !w_empty;
        w_shift = w_head;
        w_state = w_empty ? IDLE : START;
      end
      default: w_state = IDLE;
    endcase
  end
endmodule
